// File: rtl/ds_pkg.sv
// ds_pkg: shared state encoding and size defaults for the 2x2 downsample sequencer.
package ds_pkg;
    localparam int ADDR_W    = 19;
    localparam int DIM_W     = 10;
    localparam int PIX_W     = 8;
    localparam int RAM_DEPTH = 263169;
    localparam int SUM_W     = PIX_W + 2;
    typedef enum logic [3:0] {IDLE, CHK, RD0, RD1, RD2, RD3, LAST, WR, FIN} state_t;
endpackage

// File: rtl/ds_addr_gen.sv
// ds_addr_gen: output-block counters, source row pointer and port A/B address generation.
module ds_addr_gen #(
    parameter int ADDR_W = ds_pkg::ADDR_W,
    parameter int DIM_W  = ds_pkg::DIM_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              step,
    input  logic [ADDR_W-1:0] src_base,
    input  logic [ADDR_W-1:0] dst_base,
    input  logic [DIM_W-1:0]  img_w,
    input  logic [DIM_W-1:0]  img_h,
    input  logic [1:0]        sel,
    output logic [ADDR_W-1:0] addr_a,
    output logic [ADDR_W-1:0] addr_b,
    output logic              bad,
    output logic              last
);
    import ds_pkg::*;
    logic [DIM_W-1:0]  w, h, c, r, ow, oh;
    logic [ADDR_W-1:0] row, dst, p00, p10;
    logic              col_end;
    assign ow      = w >> 1;
    assign oh      = h >> 1;
    assign col_end = c == ow - DIM_W'(1);
    assign last    = col_end && r == oh - DIM_W'(1);
    assign bad     = w < DIM_W'(2) || h < DIM_W'(2);
    assign p00     = row + ADDR_W'({c, 1'b0});
    assign p10     = p00 + ADDR_W'(w);
    // sel[1] picks the lower source row, sel[0] the right-hand pixel
    assign addr_a  = (sel[1] ? p10 : p00) + ADDR_W'(sel[0]);
    assign addr_b  = dst;
    always_ff @(posedge clk) begin
        if (rst) begin
            w   <= '0;
            h   <= '0;
            c   <= '0;
            r   <= '0;
            row <= '0;
            dst <= '0;
        end else if (load) begin
            w   <= img_w;
            h   <= img_h;
            c   <= '0;
            r   <= '0;
            row <= src_base;
            dst <= dst_base;
        end else if (step) begin
            dst <= dst + ADDR_W'(1);
            c   <= col_end ? '0 : c + DIM_W'(1);
            if (col_end) begin
                r   <= r + DIM_W'(1);
                row <= row + ADDR_W'({w, 1'b0});
            end
        end
    end
endmodule

// File: rtl/downsample_ctrl.sv
// downsample_ctrl: 2x2 box downsampling sequencer driving a dual-port image RAM.
// Define DS_ROUND_EN to round the average half up instead of truncating.
module downsample_ctrl #(
    parameter int ADDR_W = ds_pkg::ADDR_W,
    parameter int DIM_W  = ds_pkg::DIM_W,
    parameter int PIX_W  = ds_pkg::PIX_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_base,
    input  logic [ADDR_W-1:0] dst_base,
    input  logic [DIM_W-1:0]  img_w,
    input  logic [DIM_W-1:0]  img_h,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] ram_addr_a,
    output logic              ram_we_a,
    input  logic [PIX_W-1:0]  ram_q_a,
    output logic [ADDR_W-1:0] ram_addr_b,
    output logic [PIX_W-1:0]  ram_data_b,
    output logic              ram_we_b
);
    import ds_pkg::*;
    localparam int ACC_W = PIX_W + 2;
    state_t            state, nxt;
    logic [ACC_W-1:0]  sum;
    logic [PIX_W-1:0]  avg;
    logic [ADDR_W-1:0] addr_a, addr_b;
    logic [1:0]        sel;
    logic              err_q, bad, last, rd;
    assign rd  = state inside {RD0, RD1, RD2, RD3};
    assign sel = state == RD1 ? 2'd1 : state == RD2 ? 2'd2 : state == RD3 ? 2'd3 : 2'd0;
`ifdef DS_ROUND_EN
    assign avg = PIX_W'((sum + ACC_W'(2)) >> 2);
`else
    assign avg = PIX_W'(sum >> 2);
`endif
    ds_addr_gen #(.ADDR_W(ADDR_W), .DIM_W(DIM_W)) u_addr (
        .clk      (clk),
        .rst      (rst),
        .load     (state == IDLE && start),
        .step     (state == WR),
        .src_base (src_base),
        .dst_base (dst_base),
        .img_w    (img_w),
        .img_h    (img_h),
        .sel      (sel),
        .addr_a   (addr_a),
        .addr_b   (addr_b),
        .bad      (bad),
        .last     (last)
    );
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else state <= nxt;
    end
    // read data trails its address by one state, so the sum spans RD1..LAST
    always_ff @(posedge clk) begin
        if (rst) begin
            sum   <= '0;
            err_q <= 1'b0;
        end else begin
            if (state == CHK) err_q <= bad;
            if (state == RD1) sum <= ACC_W'(ram_q_a);
            else if (state inside {RD2, RD3, LAST}) sum <= sum + ACC_W'(ram_q_a);
        end
    end
    always_comb begin
        nxt = state;
        unique case (state)
            IDLE:    nxt = start ? CHK : IDLE;
            CHK:     nxt = bad ? FIN : RD0;
            RD0:     nxt = RD1;
            RD1:     nxt = RD2;
            RD2:     nxt = RD3;
            RD3:     nxt = LAST;
            LAST:    nxt = WR;
            WR:      nxt = last ? FIN : RD0;
            FIN:     nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end
    always_comb begin
        busy       = state != IDLE && state != FIN;
        done       = state == FIN;
        err        = state == FIN && err_q;
        ram_we_a   = 1'b0;
        ram_addr_a = rd ? addr_a : '0;
        ram_we_b   = state == WR;
        ram_addr_b = state == WR ? addr_b : '0;
        ram_data_b = state == WR ? avg : '0;
    end
endmodule
